// File: rtl/sme_pkg.sv
// sme_pkg: shared constants, error codes and loader state type for the string-matching engine feeder
package sme_pkg;
  localparam int STR_MAX_DEF = 32;
  localparam int PAT_MAX_DEF = 8;
  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_TRUNC   = 2'd1;
  localparam logic [1:0] ERR_NOSTR   = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;
  typedef enum logic [1:0] {COLLECT, PLAY, WAIT, REPORT} sme_ld_state_t;
endpackage

// File: rtl/sme_rec_buf.sv
// sme_rec_buf: record byte store with one write port and a registered, zero-when-idle read port
module sme_rec_buf #(
  parameter int DEPTH = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [7:0]    wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [7:0]    rd
);
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[wa] <= wd;
  // write-through covers a one-byte record whose only byte lands on the first read edge
  always_ff @(posedge clk or posedge reset)
    if (reset) rd <= '0;
    else rd <= !re ? '0 : (we && wa == ra) ? wd : mem[ra];
endmodule

// File: rtl/sme_loader.sv
// sme_loader: buffers framed string/pattern records and replays them to the string-matching engine
// Optional engine-result watchdog enabled by defining SME_LOADER_TIMEOUT_EN.
module sme_loader import sme_pkg::*; #(
  parameter int STR_MAX = STR_MAX_DEF,
  parameter int PAT_MAX = PAT_MAX_DEF
`ifdef SME_LOADER_TIMEOUT_EN
  , parameter int TO_CYCLES = 255
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_pat,
  input  logic       in_last,
  output logic [7:0] sme_chardata,
  output logic       sme_isstring,
  output logic       sme_ispattern,
  input  logic       sme_valid,
  input  logic       sme_match,
  input  logic [4:0] sme_index,
  output logic       res_valid,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic [1:0] res_err
);
  localparam int AW = $clog2(STR_MAX);
  localparam logic [5:0] SMAX = 6'(STR_MAX);
  localparam logic [5:0] PMAX = 6'(PAT_MAX);
  localparam logic [5:0] WSAT = 6'(STR_MAX + 1);
  sme_ld_state_t st, st_n;
  logic kind, kind_n, trunc, trunc_n, have_str, have_n;
  logic [5:0] wr_ptr, wr_n, rd_ptr, rd_n, len, len_n, lim, cnt;
  logic acc, k, we, re, str_n, pat_n, rv_n, rm_n;
  logic [4:0] ri_n;
  logic [1:0] err_n;
`ifdef SME_LOADER_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = 8'(TO_CYCLES - 1);
  logic [7:0] wdog, wdog_n;
`endif
  sme_rec_buf #(.DEPTH(STR_MAX), .AW(AW)) u_buf (
    .clk(clk), .reset(reset), .we(we), .wa(wr_ptr[AW-1:0]), .wd(in_data),
    .re(re), .ra(rd_ptr[AW-1:0]), .rd(sme_chardata)
  );
  always_comb begin
    acc = in_valid & in_ready;
    k = (wr_ptr == '0) ? in_pat : kind;
    lim = k ? PMAX : SMAX;
    cnt = wr_ptr + 6'd1;
    st_n = st;
    kind_n = kind;
    trunc_n = trunc;
    have_n = have_str;
    wr_n = wr_ptr;
    rd_n = rd_ptr;
    len_n = len;
    we = 1'b0;
    re = 1'b0;
    str_n = 1'b0;
    pat_n = 1'b0;
    rv_n = 1'b0;
    rm_n = 1'b0;
    ri_n = '0;
    err_n = ERR_OK;
`ifdef SME_LOADER_TIMEOUT_EN
    wdog_n = wdog;
`endif
    case (st)
      COLLECT: if (acc) begin
        kind_n = k;
        we = wr_ptr < lim;
        trunc_n = trunc | (wr_ptr >= lim);
        wr_n = (wr_ptr == WSAT) ? wr_ptr : cnt;
        if (in_last) begin
          len_n = (cnt < lim) ? cnt : lim;
          wr_n = '0;
          if (k && !have_str) begin
            st_n = REPORT;
            rv_n = 1'b1;
            err_n = ERR_NOSTR;
          end else begin
            st_n = PLAY;
            re = 1'b1;
            rd_n = 6'd1;
            str_n = !k;
            pat_n = k;
          end
        end
      end
      PLAY: if (rd_ptr < len) begin
        re = 1'b1;
        rd_n = rd_ptr + 6'd1;
        str_n = !kind;
        pat_n = kind;
      end else begin
        rd_n = '0;
        if (kind) begin
          st_n = WAIT;
`ifdef SME_LOADER_TIMEOUT_EN
          wdog_n = '0;
`endif
        end else begin
          have_n = 1'b1;
          st_n = trunc ? REPORT : COLLECT;
          rv_n = trunc;
          err_n = trunc ? ERR_TRUNC : ERR_OK;
        end
      end
      WAIT: if (sme_valid) begin
        st_n = REPORT;
        rv_n = 1'b1;
        rm_n = sme_match;
        ri_n = sme_index;
        err_n = trunc ? ERR_TRUNC : ERR_OK;
      end
`ifdef SME_LOADER_TIMEOUT_EN
      else if (wdog == TO_LIM) begin
        st_n = REPORT;
        rv_n = 1'b1;
        err_n = ERR_TIMEOUT;
      end else wdog_n = wdog + 8'd1;
`endif
      REPORT: begin
        st_n = COLLECT;
        trunc_n = 1'b0;
        wr_n = '0;
        rd_n = '0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st <= COLLECT;
      kind <= 1'b0;
      trunc <= 1'b0;
      have_str <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      len <= '0;
      in_ready <= 1'b0;
      sme_isstring <= 1'b0;
      sme_ispattern <= 1'b0;
      res_valid <= 1'b0;
      res_match <= 1'b0;
      res_index <= '0;
      res_err <= ERR_OK;
`ifdef SME_LOADER_TIMEOUT_EN
      wdog <= '0;
`endif
    end else begin
      st <= st_n;
      kind <= kind_n;
      trunc <= trunc_n;
      have_str <= have_n;
      wr_ptr <= wr_n;
      rd_ptr <= rd_n;
      len <= len_n;
      in_ready <= st_n == COLLECT;
      sme_isstring <= str_n;
      sme_ispattern <= pat_n;
      res_valid <= rv_n;
      res_match <= rm_n;
      res_index <= ri_n;
      res_err <= err_n;
`ifdef SME_LOADER_TIMEOUT_EN
      wdog <= wdog_n;
`endif
    end
endmodule

// File: tb/tb_sme_loader.sv
// tb_sme_loader: scoreboard bench for sme_loader; timeout case built when SME_LOADER_TIMEOUT_EN is defined
module tb_sme_loader;
  import sme_pkg::*;
  logic clk = 0, reset = 1, in_valid = 0, in_pat = 0, in_last = 0, sme_valid = 0, sme_match = 0;
  logic [7:0] in_data = 0;
  logic [4:0] sme_index = 0;
  logic in_ready, sme_isstring, sme_ispattern, res_valid, res_match;
  logic [7:0] sme_chardata;
  logic [4:0] res_index;
  logic [1:0] res_err;

  sme_loader dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_pat(in_pat), .in_last(in_last), .sme_chardata(sme_chardata), .sme_isstring(sme_isstring),
    .sme_ispattern(sme_ispattern), .sme_valid(sme_valid), .sme_match(sme_match),
    .sme_index(sme_index), .res_valid(res_valid), .res_match(res_match),
    .res_index(res_index), .res_err(res_err)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [9:0] v; int c;} exp_t;
  exp_t sq[$], rq[$];
  int n_chk = 0, n_pass = 0, t_last = 0, len_last = 0, e_wait = 0;
  logic [7:0] rec[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input string s);
    rec.delete();
    for (int i = 0; i < s.len(); i++) rec.push_back(s[i]);
  endtask

  task automatic send_rec(input logic p);
    int n;
    for (int i = 0; i < rec.size(); i++) begin
      n = 0;
      in_valid = 1;
      in_pat = p;
      in_data = rec[i];
      in_last = (i == rec.size() - 1);
      while (!in_ready && n < 300) begin
        step;
        n++;
      end
      if (!in_ready) begin
        n_chk++;
        $display("FAIL accept_timeout: byte %0d never accepted", i);
      end
      t_last = cyc;
      step;
    end
    in_valid = 0;
    in_last = 0;
    len_last = (rec.size() < (p ? 8 : 32)) ? rec.size() : (p ? 8 : 32);
  endtask

  task automatic push_play(input logic p);
    for (int i = 0; i < len_last; i++) sq.push_back('{v: {~p, p, rec[i]}, c: t_last + 1 + i});
  endtask

  task automatic push_res(input logic m, input logic [4:0] idx, input logic [1:0] err, input int c);
    rq.push_back('{v: {2'b0, m, idx, err}, c: c});
  endtask

  task automatic ready_at(input int c);
    while (cyc < c - 1) step;
    chk("ready_low", 32'(in_ready), 0);
    step;
    chk("ready_high", 32'(in_ready), 1);
  endtask

  task automatic engine(input int gap, input logic m, input logic [4:0] idx, input logic [1:0] err);
    int w;
    w = t_last + len_last + 1 + gap;
    while (cyc < w) step;
    sme_valid = 1;
    sme_match = m;
    sme_index = idx;
    push_res(m, idx, err, w + 1);
    step;
    sme_valid = 0;
    sme_match = 0;
    sme_index = 0;
    ready_at(w + 2);
  endtask

  always @(negedge clk) if (!reset) begin
    exp_t e;
    chk("strobe_excl", 32'(sme_isstring & sme_ispattern), 0);
    if (sme_isstring | sme_ispattern) begin
      if (sq.size() == 0) begin
        n_chk++;
        $display("FAIL strobe_unexpected: data %0h at cycle %0d", sme_chardata, cyc);
      end else begin
        e = sq.pop_front();
        chk("strobe", 32'({sme_isstring, sme_ispattern, sme_chardata}), 32'(e.v));
        chk("strobe_cycle", cyc, e.c);
      end
    end else chk("idle_data", 32'(sme_chardata), 0);
    if (res_valid) begin
      if (rq.size() == 0) begin
        n_chk++;
        $display("FAIL result_unexpected: err %0d at cycle %0d", res_err, cyc);
      end else begin
        e = rq.pop_front();
        chk("result", 32'({2'b0, res_match, res_index, res_err}), 32'(e.v));
        chk("result_cycle", cyc, e.c);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", 32'(in_ready), 0);
    chk("reset_outs", 32'({sme_chardata, sme_isstring, sme_ispattern, res_valid, res_match, res_index, res_err}), 0);
    reset = 0;
    #1;
    chk("ready_at_release", 32'(in_ready), 0);
    step;
    chk("ready_rise", 32'(in_ready), 1);
    load("^A");
    send_rec(1);
    push_res(0, 0, ERR_NOSTR, t_last + 1);
    ready_at(t_last + 2);
    load("HELLO WORLD");
    send_rec(0);
    push_play(0);
    ready_at(t_last + len_last + 1);
    load("WOR");
    send_rec(1);
    push_play(1);
    sme_valid = 1;
    sme_match = 1;
    sme_index = 31;
    step;
    sme_valid = 0;
    sme_match = 0;
    sme_index = 0;
    engine(2, 1, 6, ERR_OK);
    rec.delete();
    for (int i = 0; i < 40; i++) rec.push_back(8'(i + 'h40));
    send_rec(0);
    push_play(0);
    push_res(0, 0, ERR_TRUNC, t_last + len_last + 1);
    ready_at(t_last + len_last + 2);
    load("AB");
    send_rec(1);
    push_play(1);
    engine(0, 0, 9, ERR_OK);
    load("0123456789");
    send_rec(1);
    push_play(1);
    engine(1, 1, 2, ERR_TRUNC);
    load("XY");
    send_rec(1);
    push_play(1);
    engine(3, 1, 3, ERR_OK);
    load("Z");
    send_rec(1);
    push_play(1);
    engine(0, 1, 0, ERR_OK);
`ifdef SME_LOADER_TIMEOUT_EN
    load("T");
    send_rec(1);
    push_play(1);
    e_wait = t_last + len_last + 1;
    push_res(0, 0, ERR_TIMEOUT, e_wait + 255);
    ready_at(e_wait + 256);
`endif
    rec.delete();
    for (int i = 0; i < 20; i++) rec.push_back(8'(i + 'h61));
    send_rec(0);
    push_play(0);
    step;
    step;
    reset = 1;
    #1;
    chk("reset_play_strobes", 32'({sme_isstring, sme_ispattern, sme_chardata}), 0);
    sq.delete();
    step;
    step;
    reset = 0;
    #1;
    chk("ready_after_rerelease", 32'(in_ready), 0);
    step;
    chk("ready_rerise", 32'(in_ready), 1);
    load("Q");
    send_rec(1);
    push_res(0, 0, ERR_NOSTR, t_last + 1);
    ready_at(t_last + 2);
    repeat (5) step;
    chk("strobes_drained", sq.size(), 0);
    chk("results_drained", rq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sme_loader.md
# sme_loader

Upstream feeder for the string-matching engine. Accepts a framed byte stream (string and pattern records) over a valid/ready handshake, buffers one record at a time, then replays it to the engine as `isstring`/`ispattern` strobes. It holds both strobes low while the engine computes, and returns the engine's `valid`/`match`/`match_index` as a one-cycle result with an error code.

## Interface
- `STR_MAX`, 32: max string record length in bytes; buffer depth.
- `PAT_MAX`, 8: max pattern record length in bytes.
- `TO_CYCLES`, 255: WAIT watchdog limit; used only with the timeout feature.

- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: upstream byte valid.
- `in_ready` out 1: loader accepts a byte this cycle.
- `in_data` in 8: record byte.
- `in_pat` in 1: record kind (1 = pattern, 0 = string). Sampled on the first byte of a record only.
- `in_last` in 1: this byte closes the record.
- `sme_chardata` out 8: byte to the engine.
- `sme_isstring` out 1: string strobe.
- `sme_ispattern` out 1: pattern strobe.
- `sme_valid` in 1: engine result strobe.
- `sme_match` in 1: engine match flag.
- `sme_index` in 5: engine match index.
- `res_valid` out 1: one-cycle result pulse.
- `res_match` out 1: match flag.
- `res_index` out 5: match index.
- `res_err` out 2: 0 ok, 1 truncated, 2 pattern with no prior string, 3 timeout.

## Operation
- **States:** COLLECT, PLAY, WAIT, REPORT. Reset state is COLLECT.
- **COLLECT**
  - `in_ready` = 1. Each accepted byte is written to `buf[wr_ptr]`.
  - The first byte of a record latches `kind`.
  - Bytes beyond the kind's limit (STR_MAX or PAT_MAX) are accepted and discarded, and `trunc` is set.
  - On an accepted byte with `in_last` = 1: `len` = min(count, limit).
  - If `kind` = pattern and `have_string` = 0, go to REPORT with err 2. Otherwise go to PLAY.
- **PLAY**
  - `in_ready` = 0. Each cycle drives `sme_chardata` = `buf[rd_ptr]` with exactly one strobe set per `kind`, for `len` consecutive cycles.
  - String record, after its last byte: set `have_string`. Go to REPORT with err 1 if `trunc`, else go to COLLECT.
  - Pattern record, after its last byte: go to WAIT.
- **WAIT**
  - Both strobes 0. `sme_valid` = 1 captures `sme_match`/`sme_index` and goes to REPORT with err = `trunc` ? 1 : 0.
  - `sme_valid` outside WAIT is ignored.
- **REPORT**
  - `res_valid` = 1 for one cycle. `res_match`/`res_index` are the captured values; both are 0 for err 2 and err 3.
  - Clear `trunc`, `wr_ptr`, `rd_ptr`, then go to COLLECT.
  - `have_string` is unaffected: several patterns may follow one string.
- **Idle outputs:** `sme_chardata` = 0 whenever no strobe is high. Strobes are never high together.
- **Widths:** `wr_ptr` counts to STR_MAX+1 so it saturates without wrapping. `len` is 6 bits.
- **Reset mid-operation:** all state is cleared, including `have_string`. Any partially played record is abandoned and no result is emitted.

## Timing
- Reset values: `in_ready`, `sme_chardata`, `sme_isstring`, `sme_ispattern`, `res_valid`, `res_match`, `res_index`, `res_err` are all 0. `in_ready` rises on the first clock after reset release.
- Last byte accepted at cycle t: first strobe at t+1; strobes occupy t+1 .. t+len.
- Pattern: WAIT from t+len+1. With `sme_valid` sampled at cycle w: `res_valid` at w+1, `in_ready` = 1 at w+2.
- Untruncated string record: `in_ready` = 1 again at t+len+1.
- Err-2 pattern: `res_valid` at t+1, `in_ready` at t+2.
- All outputs are registered.

## Configuration
- **`SME_LOADER_TIMEOUT_EN` defined:**
  - An 8-bit watchdog clears on WAIT entry and increments each WAIT cycle.
  - Reaching TO_CYCLES without `sme_valid` goes to REPORT with err 3.
  - `sme_valid` on the same cycle as the limit wins: a normal result is reported.
- **Not defined:** WAIT holds indefinitely and `TO_CYCLES` is unused.

## Structure
- Package `sme_pkg`:
  - STR_MAX / PAT_MAX defaults.
  - Error-code constants ERR_OK, ERR_TRUNC, ERR_NOSTR, ERR_TIMEOUT.
  - State enum `sme_ld_state_t`.
- Sub-module `sme_rec_buf`: 32×8 register file with write port and registered read at `rd_ptr`. No reset on data; pointers live in the parent.

## Test plan
- String "HELLO WORLD" (11 B), then pattern "WOR", engine returns match=1 index=6 → `isstring` high 11 cycles, `ispattern` 3 cycles, `res_valid` with match=1 index=6 err=0.
- Pattern "^A" right after reset → no strobes; `res_valid` at t+1 with err=2, match=0.
- 40-byte string → 32 `isstring` cycles; `res_valid` with err=1; subsequent pattern result has err=0.
- 10-byte pattern → 8 `ispattern` cycles; result err=1.
- Two patterns after one string, engine returns index 3 then 0 → two results with no re-sent string.
- With `SME_LOADER_TIMEOUT_EN`, engine never asserts valid → `res_valid` exactly 255 cycles after WAIT entry, err=3. Also assert reset during PLAY → strobes drop immediately, no result, next pattern gives err=2.
